// File: rtl/ehgu_basic_pkg.sv
// Purpose : shared enums, sizes and helpers for the basic ehgu building blocks.
// Ports   : none (package only).
// Notes   : bin2therm turns a small binary count into a right-aligned thermometer code.
package ehgu_basic_pkg;

  typedef enum logic {
    EHGU_CNT_WRAP = 1'b0,
    EHGU_CNT_SAT  = 1'b1
  } ehgu_cnt_mode_e;

  // Thermometer output width, and the binary width able to hold 0..THERM_SIZE.
  localparam int THERM_SIZE           = 8;
  localparam int BINARY_OF_THERM_SIZE = $clog2(THERM_SIZE + 1);

  // Sets the lowest n bits; n == THERM_SIZE gives all ones.
  function automatic logic [THERM_SIZE-1:0] bin2therm(input logic [BINARY_OF_THERM_SIZE-1:0] n);
    logic [THERM_SIZE-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_SIZE; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

endpackage : ehgu_basic_pkg

// File: rtl/ehgu_config_pkg.sv
// Purpose : project-wide datapath configuration shared by the ehgu blocks.
// Ports   : none (package only).
// Notes   : DP_WIDTH is the default width for datapath counters and registers.
package ehgu_config_pkg;

  localparam int DP_WIDTH = 8;

endpackage : ehgu_config_pkg

// File: rtl/ehgu_gray_reg.sv
// Purpose : registers the gray-code image of a binary value.
// Latency : one cycle from bin_in to gray_out; no backpressure, holds while en is low.
// Ports   : clk, rst (sync, active-high), en (hold when low), bin_in -> gray_out.
module ehgu_gray_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] r_gray;

  assign w_gray = bin_in ^ (bin_in >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray <= '0;
    end else if (en) begin
      r_gray <= w_gray;
    end
  end

  assign gray_out = r_gray;

endmodule : ehgu_gray_reg

// File: rtl/ehgu_mod_counter.sv
// Purpose : up/down modulo counter with load, wrap/saturate mode and binary + gray outputs.
// Latency : single cycle, every output registered; no backpressure, en=0 freezes state.
// Ports   : clk, rst (sync, active-high), en, inc, dec, load, load_val, modulo (0 = 2**WIDTH)
//           -> count_bin, count_gray, wrap, at_zero, at_max, illegal
//           [+ therm_out when EHGU_MOD_COUNTER_THERM_EN is defined].
module ehgu_mod_counter
  import ehgu_basic_pkg::*;
#(
  parameter int             WIDTH = ehgu_config_pkg::DP_WIDTH,
  parameter ehgu_cnt_mode_e MODE  = EHGU_CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH:0]   modulo,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap,
  output logic             at_zero,
  output logic             at_max,
  output logic             illegal
`ifdef EHGU_MOD_COUNTER_THERM_EN
  ,
  output logic [THERM_SIZE-1:0] therm_out
`endif
);

  // One extra bit so modulo = 2**WIDTH and +1 from all-ones stay representable.
  localparam int XW = WIDTH + 1;

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_illegal;
  logic             r_at_zero;
  logic             r_at_max;

  logic [XW-1:0]    w_eff_mod;
  logic [XW-1:0]    w_max;
  logic [XW-1:0]    w_cnt_x;
  logic [XW-1:0]    w_load_x;
  logic [XW-1:0]    w_next_x;
  logic [WIDTH-1:0] w_next_bin;
  logic             w_wrap_evt;
  logic             w_illegal_evt;

  assign w_eff_mod = (modulo == '0) ? {1'b1, {WIDTH{1'b0}}} : modulo;
  assign w_max     = w_eff_mod - XW'(1);
  assign w_cnt_x   = {1'b0, r_cnt};
  assign w_load_x  = {1'b0, load_val};

  always_comb begin
    w_next_x      = w_cnt_x;
    w_wrap_evt    = 1'b0;
    w_illegal_evt = 1'b0;
    if (load) begin
      if (w_load_x >= w_eff_mod) begin
        w_next_x      = w_load_x % w_eff_mod;
        w_illegal_evt = 1'b1;
      end else begin
        w_next_x = w_load_x;
      end
    end else if (inc && dec) begin
      w_next_x = w_cnt_x;
    end else if (inc) begin
      if (w_cnt_x < w_max) begin
        w_next_x = w_cnt_x + XW'(1);
      end else if ((w_cnt_x == w_max) && (MODE == EHGU_CNT_SAT)) begin
        w_next_x = w_cnt_x;
      end else begin
        // Either the top of the range, or a count stranded above a lowered modulo.
        w_next_x   = '0;
        w_wrap_evt = (MODE == EHGU_CNT_WRAP);
      end
    end else if (dec) begin
      if (w_cnt_x >= w_eff_mod) begin
        // Stranded above a lowered modulo: snap to the new top, not a wrap.
        w_next_x = w_max;
      end else if (w_cnt_x == '0) begin
        if (MODE == EHGU_CNT_WRAP) begin
          w_next_x   = w_max;
          w_wrap_evt = 1'b1;
        end
      end else begin
        w_next_x = w_cnt_x - XW'(1);
      end
    end
  end

  // Always below 2**WIDTH, so the extra bit is zero here.
  assign w_next_bin = w_next_x[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
      r_at_zero <= 1'b1;
      r_at_max  <= (modulo == XW'(1));
    end else if (en) begin
      r_cnt     <= w_next_bin;
      r_wrap    <= w_wrap_evt;
      r_illegal <= w_illegal_evt;
      r_at_zero <= (w_next_x == '0);
      r_at_max  <= (w_next_x == w_max);
    end else begin
      // Event flags are one-cycle pulses; they must not stretch while frozen.
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  // Gray is derived from the same next value as r_cnt, so the two never disagree.
  ehgu_gray_reg #(
    .WIDTH (WIDTH)
  ) u_gray_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bin_in   (w_next_bin),
    .gray_out (count_gray)
  );

  assign count_bin = r_cnt;
  assign wrap      = r_wrap;
  assign illegal   = r_illegal;
  assign at_zero   = r_at_zero;
  assign at_max    = r_at_max;

`ifdef EHGU_MOD_COUNTER_THERM_EN
  logic [31:0]                     w_next_32;
  logic [BINARY_OF_THERM_SIZE-1:0] w_therm_n;
  logic [THERM_SIZE-1:0]           r_therm;

  assign w_next_32 = 32'(w_next_x);
  assign w_therm_n = (w_next_32 > 32'(THERM_SIZE)) ? BINARY_OF_THERM_SIZE'(THERM_SIZE)
                                                   : BINARY_OF_THERM_SIZE'(w_next_32);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_therm <= '0;
    end else if (en) begin
      r_therm <= bin2therm(w_therm_n);
    end
  end

  assign therm_out = r_therm;
`endif

endmodule : ehgu_mod_counter

// File: tb/tb_ehgu_mod_counter.sv
// Purpose : self-checking bench for ehgu_mod_counter, one WRAP and one SAT instance on shared stimulus.
// Latency : outputs compared every falling edge against an integer model of the counting rules.
// Ports   : none (top-level bench).
module tb_ehgu_mod_counter;
  import ehgu_basic_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         inc;
  logic         dec;
  logic         load;
  logic [W-1:0] load_val;
  logic [W:0]   modulo;

  logic [W-1:0] cb [2];
  logic [W-1:0] cg [2];
  logic         wr [2];
  logic         az [2];
  logic         am [2];
  logic         il [2];
`ifdef EHGU_MOD_COUNTER_THERM_EN
  logic [THERM_SIZE-1:0] th [2];
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state, index 0 = WRAP instance, 1 = SAT instance.
  int m_cnt   [2];
  bit m_wrap  [2];
  bit m_ill   [2];
  bit m_atmax [2];

  int exp26 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  ehgu_mod_counter #(.WIDTH(W), .MODE(EHGU_CNT_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .modulo(modulo),
    .count_bin(cb[0]), .count_gray(cg[0]), .wrap(wr[0]), .at_zero(az[0]),
    .at_max(am[0]), .illegal(il[0])
`ifdef EHGU_MOD_COUNTER_THERM_EN
    , .therm_out(th[0])
`endif
  );

  ehgu_mod_counter #(.WIDTH(W), .MODE(EHGU_CNT_SAT)) u_sat (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .modulo(modulo),
    .count_bin(cb[1]), .count_gray(cg[1]), .wrap(wr[1]), .at_zero(az[1]),
    .at_max(am[1]), .illegal(il[1])
`ifdef EHGU_MOD_COUNTER_THERM_EN
    , .therm_out(th[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Counting rules applied with plain integer arithmetic; k selects the mode.
  task automatic model_step(input int k);
    int eff;
    int lv;
    eff = (modulo == 0) ? (1 << W) : int'(modulo);
    lv  = int'(load_val);
    if (rst) begin
      m_cnt[k]   = 0;
      m_wrap[k]  = 0;
      m_ill[k]   = 0;
      m_atmax[k] = (eff == 1);
    end else if (!en) begin
      m_wrap[k] = 0;
      m_ill[k]  = 0;
    end else begin
      m_wrap[k] = 0;
      m_ill[k]  = 0;
      if (load) begin
        m_cnt[k] = lv % eff;
        m_ill[k] = (lv >= eff);
      end else if (inc && dec) begin
        m_cnt[k] = m_cnt[k];
      end else if (inc) begin
        if (m_cnt[k] < eff - 1) m_cnt[k] = m_cnt[k] + 1;
        else if (m_cnt[k] == eff - 1 && k == 1) m_cnt[k] = m_cnt[k];
        else begin
          m_cnt[k]  = 0;
          m_wrap[k] = (k == 0);
        end
      end else if (dec) begin
        if (m_cnt[k] >= eff) m_cnt[k] = eff - 1;
        else if (m_cnt[k] == 0) begin
          if (k == 0) begin
            m_cnt[k]  = eff - 1;
            m_wrap[k] = 1;
          end
        end else m_cnt[k] = m_cnt[k] - 1;
      end
      m_atmax[k] = (m_cnt[k] == eff - 1);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cmp%0d.count_bin", k), 32'(cb[k]), 32'(m_cnt[k]));
        check($sformatf("cmp%0d.count_gray", k), 32'(cg[k]), 32'(m_cnt[k] ^ (m_cnt[k] >> 1)));
        check($sformatf("cmp%0d.wrap", k), 32'(wr[k]), 32'(m_wrap[k]));
        check($sformatf("cmp%0d.illegal", k), 32'(il[k]), 32'(m_ill[k]));
        check($sformatf("cmp%0d.at_zero", k), 32'(az[k]), 32'(m_cnt[k] == 0));
        check($sformatf("cmp%0d.at_max", k), 32'(am[k]), 32'(m_atmax[k]));
`ifdef EHGU_MOD_COUNTER_THERM_EN
        check($sformatf("cmp%0d.therm_out", k), 32'(th[k]),
              32'((1 << ((m_cnt[k] > THERM_SIZE) ? THERM_SIZE : m_cnt[k])) - 1));
`endif
      end
    end
  end

  // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
  task automatic drive(input bit r, input bit e, input bit i, input bit d, input bit l,
                       input logic [W-1:0] lv, input logic [W:0] m);
    rst = r; en = e; inc = i; dec = d; load = l; load_val = lv; modulo = m;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0;
    load_val = '0; modulo = 5'd1;
    @(negedge clk);
    chk_en = 1'b1;
    check("lit_rst_at_max_mod1", 32'(am[0]), 32'd1);

    drive(1, 0, 0, 0, 0, 0, 10);
    check("lit_rst_count", 32'(cb[0]), 32'd0);
    check("lit_rst_at_zero", 32'(az[0]), 32'd1);
    check("lit_rst_at_max_mod10", 32'(am[0]), 32'd0);

    // Twelve increments, modulo 10.
    for (int n = 0; n < 12; n++) begin
      drive(0, 1, 1, 0, 0, 0, 10);
      check($sformatf("lit_inc%0d_count", n), 32'(cb[0]), 32'(exp26[n]));
      check($sformatf("lit_inc%0d_wrap", n), 32'(wr[0]), (n == 9) ? 32'd1 : 32'd0);
      if (n == 8) check("lit_gray_at_9", 32'(cg[0]), 32'hD);
    end
    check("lit_sat_hold9", 32'(cb[1]), 32'd9);

    // Decrement from zero, then inc and dec together.
    drive(1, 1, 0, 0, 0, 0, 10);
    drive(0, 1, 0, 1, 0, 0, 10);
    check("lit_dec0_wrap_count", 32'(cb[0]), 32'd9);
    check("lit_dec0_wrap_pulse", 32'(wr[0]), 32'd1);
    check("lit_dec0_sat_count", 32'(cb[1]), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 10);
    check("lit_wrap_one_cycle", 32'(wr[0]), 32'd0);
    drive(0, 1, 0, 0, 1, 5, 10);
    drive(0, 1, 1, 1, 0, 0, 10);
    check("lit_incdec_hold", 32'(cb[0]), 32'd5);

    // Out-of-range load, then load against inc.
    drive(0, 1, 0, 0, 1, 12, 10);
    check("lit_load12_count", 32'(cb[0]), 32'd2);
    check("lit_load12_illegal", 32'(il[0]), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 10);
    check("lit_illegal_one_cycle", 32'(il[0]), 32'd0);
    drive(0, 1, 1, 0, 1, 3, 10);
    check("lit_load_beats_inc", 32'(cb[0]), 32'd3);

    // Full range (modulo 0 = 16), saturate at 15.
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) drive(0, 1, 1, 0, 0, 0, 0);
    check("lit_sat15_count", 32'(cb[1]), 32'd15);
    check("lit_sat15_at_max", 32'(am[1]), 32'd1);
    check("lit_wrap16_count", 32'(cb[0]), 32'd4);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("lit_sat_dec14", 32'(cb[1]), 32'd14);

    // Modulo lowered below the current count.
    drive(0, 1, 0, 0, 1, 12, 0);
    drive(0, 1, 0, 0, 0, 0, 10);
    check("lit_lowered_noop_hold", 32'(cb[0]), 32'd12);
    drive(0, 1, 1, 0, 0, 0, 10);
    check("lit_lowered_inc_zero", 32'(cb[0]), 32'd0);
    check("lit_lowered_inc_wrap", 32'(wr[0]), 32'd1);
    check("lit_lowered_inc_sat_nowrap", 32'(wr[1]), 32'd0);
    drive(0, 1, 0, 0, 1, 12, 0);
    drive(0, 1, 0, 1, 0, 0, 10);
    check("lit_lowered_dec_top", 32'(cb[1]), 32'd9);

    // Enable low freezes the count.
    drive(0, 1, 0, 0, 1, 7, 10);
`ifdef EHGU_MOD_COUNTER_THERM_EN
    check("lit_therm_at7", 32'(th[0]), 32'h7F);
`endif
    drive(0, 0, 1, 0, 0, 0, 10);
    drive(0, 0, 0, 0, 1, 2, 10);
    check("lit_en_low_hold", 32'(cb[0]), 32'd7);

    // Reset beats inc.
    drive(1, 1, 1, 0, 0, 0, 10);
    check("lit_rst_inc_count", 32'(cb[0]), 32'd0);
    check("lit_rst_inc_at_zero", 32'(az[0]), 32'd1);
    check("lit_rst_inc_wrap", 32'(wr[0]), 32'd0);
`ifdef EHGU_MOD_COUNTER_THERM_EN
    check("lit_therm_rst", 32'(th[0]), 32'd0);
`endif

    // Reset on what would be a wrap cycle.
    drive(0, 1, 0, 0, 1, 9, 10);
    drive(1, 1, 1, 0, 0, 0, 10);
    check("lit_rst_kills_wrap", 32'(wr[0]), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 10);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ehgu_mod_counter

// File: doc/ehgu_mod_counter.md
EHGU_MOD_COUNTER -- requirements
Module: ehgu_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default ehgu_config_pkg::DP_WIDTH; sets the counter width in bits.
REQ-002 SHALL have parameter MODE, default EHGU_CNT_WRAP, of type ehgu_cnt_mode_e; selects EHGU_CNT_WRAP or EHGU_CNT_SAT.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit; global enable, and SHALL hold all state when low.
REQ-006 SHALL have ports inc and dec, input, 1 bit each; step the count up or down by one.
REQ-007 SHALL have ports load (input, 1 bit) and load_val (input, WIDTH bits); synchronous load.
REQ-008 SHALL have port modulo, input, WIDTH+1 bits; count range is 0..modulo-1, and the value 0 SHALL mean 2**WIDTH.
REQ-009 SHALL have outputs count_bin and count_gray, WIDTH bits each, both registered.
REQ-010 SHALL have outputs wrap, at_zero, at_max and illegal, 1 bit each, all registered.

Function
REQ-011 SHALL apply operations only when en=1, with priority load > (inc&dec: no change) > inc > dec.
REQ-012 SHALL give single-cycle latency: count_bin and count_gray reflect an operation on the edge that samples it.
REQ-013 SHALL compute count_gray = next_bin ^ (next_bin>>1) from next_bin and register it, so count_gray and count_bin never disagree.
REQ-014 In WRAP mode, inc at modulo-1 SHALL go to 0 and dec at 0 SHALL go to modulo-1; each such event SHALL pulse wrap for exactly one cycle.
REQ-015 In SAT mode, inc at modulo-1 and dec at 0 SHALL hold the count, and wrap SHALL stay 0.
REQ-016 If modulo is lowered so that count_bin >= modulo: inc SHALL go to 0 (wrap pulses in WRAP mode), dec SHALL go to modulo-1, and no-op SHALL hold.
REQ-017 A load with load_val >= effective modulo SHALL load load_val mod effective modulo and pulse illegal for one cycle.
REQ-018 at_zero SHALL equal (count_bin==0) and at_max SHALL equal (count_bin==effective modulo-1), both evaluated on the registered value.
REQ-019 All arithmetic SHALL use WIDTH+1 bits internally so that modulo=2**WIDTH and inc at all-ones do not overflow.

Reset
REQ-020 On rst=1 at a clock edge, count_bin, count_gray, wrap and illegal SHALL be 0, at_zero SHALL be 1, and at_max SHALL be (modulo==1).
REQ-021 rst SHALL override load, inc, dec and en; a reset during a wrap cycle SHALL suppress the wrap pulse.

Configuration
REQ-022 Macro EHGU_MOD_COUNTER_THERM_EN defined: the block SHALL add output therm_out, THERM_SIZE bits, registered, equal to bin2therm(min(count_bin, THERM_SIZE)), with reset value 0.
REQ-023 Macro EHGU_MOD_COUNTER_THERM_EN undefined: the therm_out port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Typedef ehgu_cnt_mode_e SHALL live in ehgu_basic_pkg, and the block SHALL reuse THERM_SIZE and BINARY_OF_THERM_SIZE from that package.
REQ-025 The gray conversion and register SHALL be one sub-module, ehgu_gray_reg (parameter WIDTH, inputs clk/rst/en/bin_in, output gray_out); the rest SHALL be flat.

Verification
REQ-026 WIDTH=4, WRAP, modulo=10, 12 incs from reset -> count_bin goes 1..9,0,1,2; wrap high only on the 0 cycle; count_gray 0xD when count_bin=9.
REQ-027 WIDTH=4, SAT, modulo=0 (i.e. 16), 20 incs -> count_bin holds at 15, at_max=1, wrap never asserts; then 1 dec -> 14.
REQ-028 WIDTH=4, WRAP, modulo=10, dec from 0 -> count_bin=9 and wrap pulses; inc&dec together at 5 -> stays 5.
REQ-029 WIDTH=4, load_val=12 with modulo=10 -> count_bin=2 and illegal pulses one cycle; load together with inc -> load wins.
REQ-030 count at 7, then assert rst together with inc -> count_bin=0, at_zero=1, wrap=0; with the macro defined, therm_out=0 after reset and equals 0x7F at count 7.
